hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the 5-stage core. It detects load-use hazards, taken-branch redirects and multi-cycle data-memory waits. It drives the stall (hold) and clear (bubble) controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It is the producer side of the stall/clear interface consumed by every pipeline register (stall = 1 holds contents, clear = 1 loads zeros), and it also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- `TIMEOUT`, default 64: maximum number of consecutive memory-wait cycles before the error state is entered.
- `CNT_W`, default 32: width of the stall-cycle counter.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `id_rs_addr_i` in 5: rs of the instruction in ID.
- `id_rt_addr_i` in 5: rt of the instruction in ID.
- `id_rt_used_i` in 1: the ID instruction reads rt (not an immediate form).
- `id_branch_taken_i` in 1: ID has resolved a taken branch or jump.
- `ex_dst_addr_i` in 5: destination register of the instruction in EX.
- `ex_mem_r_i` in 1: the EX instruction is a load.
- `ex_wb_reg_en_i` in 1: the EX instruction writes a register.
- `mem_req_i` in 1: the MEM-stage instruction accesses data memory this cycle.
- `mem_ready_i` in 1: data memory completes the access this cycle.
- `pc_stall_o` out 1: hold the PC.
- `if_id_stall_o` out 1: hold the IF/ID register.
- `if_id_clear_o` out 1: clear the IF/ID register.
- `id_ex_stall_o` out 1: hold the ID/EX register.
- `id_ex_clear_o` out 1: clear the ID/EX register.
- `ex_mem_stall_o` out 1: hold the EX/MEM register.
- `mem_wb_clear_o` out 1: clear the MEM/WB register.
- `err_o` out 1: memory timeout; sticky until reset.
- `stall_cnt_o` out CNT_W: number of cycles in which `pc_stall_o` was 1, saturating.

## Operation
- FSM states:
  - RUN: normal flow.
  - MEM_WAIT: waiting on data memory.
  - ERROR: memory timed out.
- The FSM state, `wait_cnt` (ceil(log2(TIMEOUT+1)) bits), `err_o` and `stall_cnt_o` are registered. All stall and clear outputs are combinational (Mealy) on the current state and current inputs.
- Freeze condition `frz`:
  - In RUN: `mem_req_i & ~mem_ready_i`.
  - In MEM_WAIT: `~mem_ready_i`.
  - In ERROR: always 1.
- When `frz`=1: `pc_stall_o`, `if_id_stall_o`, `id_ex_stall_o`, `ex_mem_stall_o` and `mem_wb_clear_o` are 1. All other clears are 0. Load-use and branch logic are masked.
- Load-use condition `lu`: `ex_mem_r_i & ex_wb_reg_en_i & (ex_dst_addr_i != 0) & (ex_dst_addr_i == id_rs_addr_i | (id_rt_used_i & ex_dst_addr_i == id_rt_addr_i))`.
- If `lu` and not `frz`: `pc_stall_o`, `if_id_stall_o` and `id_ex_clear_o` are 1. This inserts one bubble; `id_branch_taken_i` is ignored that cycle.
- If `id_branch_taken_i` and neither `frz` nor `lu`: `if_id_clear_o` is 1, for exactly that cycle.
- Output priority: freeze > load-use > branch.
- FSM transitions:
  - RUN → MEM_WAIT when `mem_req_i & ~mem_ready_i`; `wait_cnt` ← 1.
  - MEM_WAIT → RUN when `mem_ready_i`. Freeze is already released in this cycle, so the pipeline advances on this edge.
  - MEM_WAIT, `~mem_ready_i`, `wait_cnt == TIMEOUT` → ERROR; `err_o` ← 1.
  - MEM_WAIT, otherwise: `wait_cnt` += 1.
  - ERROR: stays in ERROR until reset.
- `stall_cnt_o` increments on each edge where `pc_stall_o` was 1. It holds at all-ones (2^CNT_W−1) once reached.

## Timing
- Reset (asynchronous, `rst`=0):
  - State is RUN; `wait_cnt`, `err_o` and `stall_cnt_o` are 0.
  - All stall/clear outputs are 0, since they are combinational from RUN with inputs don't-care masked by reset.
- Reset asserted mid-wait or in ERROR returns to RUN immediately, without waiting for a clock edge.
- Load-use costs exactly 1 cycle: the next cycle the load is in MEM and `lu` is false.
- A memory access with N wait cycles (`mem_ready_i` first high N cycles after the request) freezes the pipeline for exactly N cycles.
- A zero-wait access (`mem_ready_i` high together with `mem_req_i` in RUN) causes no freeze and no state change.
- ERROR is entered on the edge at the end of wait cycle TIMEOUT+1 (the cycle where `wait_cnt` == TIMEOUT and `mem_ready_i` is still 0). `err_o` is 1 from the following cycle.
- `mem_ready_i` arriving in the same cycle as `wait_cnt == TIMEOUT` wins: transition to RUN, no error.
- A load-use or branch arriving during a freeze is held in place by the stalls and is evaluated once the freeze releases.

## Structure
- The shared package `pipe_pkg` holds:
  - the FSM state enum (RUN, MEM_WAIT, ERROR);
  - the register-number width (5);
  - the zero-register constant.
- One sub-module, `sat_counter`, is natural: parameterised width, increment enable, saturating at all-ones.
- The hazard comparators remain inline.

## Test plan
- Load-use: `ex_mem_r_i`=1, `ex_wb_reg_en_i`=1, `ex_dst_addr_i`=5, `id_rs_addr_i`=5 → for one cycle `pc_stall_o`=`if_id_stall_o`=`id_ex_clear_o`=1; `stall_cnt_o` goes 0→1. The same case with `ex_dst_addr_i`=0, or with a rt match and `id_rt_used_i`=0, → no stall.
- Branch: `id_branch_taken_i`=1 alone → `if_id_clear_o`=1 for one cycle. The same with a simultaneous `lu` → only the load-use outputs assert.
- Memory wait: `mem_req_i`=1 with `mem_ready_i` low for 3 cycles then high → freeze outputs high for exactly 3 cycles; state RUN afterwards; `stall_cnt_o`=3.
- Timeout: `TIMEOUT`=4, `mem_ready_i` never asserted → ERROR entered and `err_o`=1 in the cycle after wait cycle 5; freeze held. A ready arriving at `wait_cnt`=4 instead → returns to RUN with `err_o`=0.
- Reset mid-MEM_WAIT and while in ERROR → all outputs 0 and `stall_cnt_o`=0 immediately after `rst` falls, before any clock edge.
- Saturation: `CNT_W`=3 with 10 stall cycles → `stall_cnt_o` reaches 7 and holds.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-number width, zero register and
// the hazard controller FSM state encoding.
package pipe_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; one-cycle update latency, no backpressure.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, memory-wait freeze.
// Stall/clear outputs are combinational on state and inputs; state, error and counter are registered.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs_addr_i,
  input  logic [REG_W-1:0] id_rt_addr_i,
  input  logic             id_rt_used_i,
  input  logic             id_branch_taken_i,
  input  logic [REG_W-1:0] ex_dst_addr_i,
  input  logic             ex_mem_r_i,
  input  logic             ex_wb_reg_en_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_clear_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_clear_o,
  output logic             ex_mem_stall_o,
  output logic             mem_wb_clear_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  localparam int WC_W = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            err_q, err_d;
  logic            frz, lu;

  always_comb begin
    unique case (state_q)
      RUN:      frz = mem_req_i & ~mem_ready_i;
      MEM_WAIT: frz = ~mem_ready_i;
      default:  frz = 1'b1;
    endcase
  end

  assign lu = ex_mem_r_i & ex_wb_reg_en_i & (ex_dst_addr_i != ZERO_REG) &
              ((ex_dst_addr_i == id_rs_addr_i) |
               (id_rt_used_i & (ex_dst_addr_i == id_rt_addr_i)));

  // Outputs are gated by reset so the pipeline sees no stall/clear while held in reset.
  assign pc_stall_o     = rst & (frz | lu);
  assign if_id_stall_o  = rst & (frz | lu);
  assign id_ex_stall_o  = rst & frz;
  assign ex_mem_stall_o = rst & frz;
  assign mem_wb_clear_o = rst & frz;
  assign id_ex_clear_o  = rst & ~frz & lu;
  assign if_id_clear_o  = rst & ~frz & ~lu & id_branch_taken_i;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    unique case (state_q)
      RUN: begin
        if (mem_req_i && !mem_ready_i) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_ready_i) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WC_W'(TIMEOUT)) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (pc_stall_o),
    .cnt_o (stall_cnt_o)
  );
endmodule
